// File: rtl/rr_dec_arbiter.sv
// 16-requester round-robin arbiter with one-hot and binary grant outputs.
// Define ARB_HOLD_TIMEOUT_EN to bound each grant to HOLD_MAX cycles with a timeout pulse.
module rr_dec_arbiter #(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [15:0] i_req,
   output logic [15:0] o_gnt,
   output logic [3:0]  o_gnt_idx,
   output logic        o_gnt_vld,
   output logic        o_timeout
);

   if ((HOLD_MAX < 2) || (HOLD_MAX > 255) || ((64'd1 << CNT_W) <= 64'(HOLD_MAX))) begin : g_param_err
      $error("rr_dec_arbiter: HOLD_MAX must be 2..255 and fit in CNT_W bits");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e      r_state, w_state_d;
   logic [3:0]  r_ptr, w_ptr_d;
   logic [3:0]  r_idx, w_idx_d;
   logic [15:0] r_gnt, w_gnt_d;
   logic        r_timeout, w_timeout_d;

   logic [3:0]  w_win;
   logic [3:0]  w_pos;
   logic        w_found;
   logic        w_start;
   logic        w_release;
   logic        w_expire;

   // Rotating priority scan: first set request at or above ptr, wrapping 15 -> 0.
   always_comb begin
      w_win   = 4'd0;
      w_pos   = 4'd0;
      w_found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         w_pos = r_ptr + 4'(i);
         if (!w_found && i_req[w_pos]) begin
            w_found = 1'b1;
            w_win   = w_pos;
         end
      end
   end

   assign w_start   = (r_state == StIdle) && i_en && w_found;
   assign w_release = (r_state == StGrant) && !i_req[r_idx];

`ifdef ARB_HOLD_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt, w_cnt_d;

   assign w_expire = (r_state == StGrant) && i_req[r_idx] &&
                     (r_cnt == CNT_W'(HOLD_MAX - 1));

   always_comb begin
      w_cnt_d = r_cnt;
      if (w_start || w_release || w_expire) begin
         w_cnt_d = '0;
      end else if (r_state == StGrant) begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_start) w_state_d = StGrant;
         StGrant: if (w_release || w_expire) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Grant datapath next values
   always_comb begin
      w_ptr_d     = r_ptr;
      w_idx_d     = r_idx;
      w_gnt_d     = r_gnt;
      w_timeout_d = 1'b0;
      if (w_start) begin
         w_idx_d = w_win;
         w_gnt_d = 16'd1 << w_win;
      end else if (w_release || w_expire) begin
         w_idx_d     = 4'd0;
         w_gnt_d     = 16'd0;
         w_ptr_d     = r_idx + 4'd1;
         w_timeout_d = w_expire;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr     <= 4'd0;
         r_idx     <= 4'd0;
         r_gnt     <= 16'd0;
         r_timeout <= 1'b0;
      end else begin
         r_ptr     <= w_ptr_d;
         r_idx     <= w_idx_d;
         r_gnt     <= w_gnt_d;
         r_timeout <= w_timeout_d;
      end
   end

   // Output logic
   always_comb begin
      o_gnt     = r_gnt;
      o_gnt_idx = r_idx;
      o_gnt_vld = |r_gnt;
      o_timeout = r_timeout;
   end

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Self-checking bench for rr_dec_arbiter: directed scenarios then random traffic
// against an integer-level round-robin reference model.
module tb_rr_dec_arbiter;

   localparam int unsigned HoldMax = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_vld;
   logic        timeout;

   always #5 clk = ~clk;

   rr_dec_arbiter #(
      .HOLD_MAX (HoldMax),
      .CNT_W    (8)
   ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_en      (en),
      .i_req     (req),
      .o_gnt     (gnt),
      .o_gnt_idx (gnt_idx),
      .o_gnt_vld (gnt_vld),
      .o_timeout (timeout)
   );

   int    n_assert = 0;
   int    n_fail   = 0;
   int    m_owner  = -1;
   int    m_ptr    = 0;
   int    m_hold   = 0;
   bit    m_to     = 1'b0;
   string g_tag    = "init";

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_pack();
      return {10'b0, gnt, gnt_idx, gnt_vld, timeout};
   endfunction

   function automatic logic [31:0] model_pack();
      logic [15:0] g;
      logic [3:0]  ix;
      g  = (m_owner >= 0) ? 16'(32'd1 << m_owner) : 16'd0;
      ix = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
      return {10'b0, g, ix, (m_owner >= 0), m_to};
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
   endtask

   // Apply the arbitration rules to the inputs seen at this clock edge.
   task automatic model_update();
      bit found;
      int c;
      m_to = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else if (m_owner < 0) begin
         found = 1'b0;
         if (en && req != 16'd0) begin
            for (int k = 0; k < 16; k++) begin
               c = (m_ptr + k) % 16;
               if (!found && req[c]) begin
                  found   = 1'b1;
                  m_owner = c;
                  m_hold  = 1;
               end
            end
         end
      end else if (!req[m_owner]) begin
         m_ptr   = (m_owner + 1) % 16;
         m_owner = -1;
      end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
         if (m_hold == int'(HoldMax)) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_hold++;
         end
`else
         m_hold++;
`endif
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      chk(g_tag, dut_pack(), model_pack());
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic sync_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int  ngr;
      bit  was_idle;

      // Reset state
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 16'd0;
      #2;
      chk("reset_out", dut_pack(), 32'h0);
      g_tag = "reset";
      step();
      rst_n = 1'b1;

      // Async reset in the middle of a grant
      g_tag = "rst_seq";
      en  = 1'b1;
      req = 16'h0020;
      step();
      chk("rst_owner5", 32'(gnt), 32'h0020);
      step();
      #3 rst_n = 1'b0;
      #1 chk("rst_midgrant", dut_pack(), 32'h0);
      model_reset();
      step();
      rst_n = 1'b1;
      step();
      chk("rst_regrant", 32'(gnt), 32'h0020);
      chk("rst_regrant_idx", 32'(gnt_idx), 32'd5);
      req = 16'd0;
      step();

      // Rotation with all requesting, 2-cycle holds
      sync_reset();
      g_tag = "rotation";
      ngr   = 0;
      for (int i = 0; i < 50; i++) begin
         req = 16'hFFFF;
         if (m_owner >= 0 && m_hold == 2) req[m_owner] = 1'b0;
         was_idle = (m_owner < 0);
         step();
         if (was_idle && m_owner >= 0) begin
            chk("rot_order", 32'(gnt_idx), 32'(ngr % 16));
            ngr++;
         end
      end
      chk("rot_count", 32'(ngr), 32'd17);
      req = 16'd0;
      step();

      // Pointer wrap
      sync_reset();
      g_tag = "wrap";
      req = 16'h2000;
      step();
      chk("wrap_own13", 32'(gnt_idx), 32'd13);
      req = 16'd0;
      step();
      req = 16'h0003;
      step();
      chk("wrap_win0", 32'(gnt_idx), 32'd0);
      req = 16'd0;
      step();
      req = 16'h8001;
      step();
      chk("wrap_win15", 32'(gnt_idx), 32'd15);
      req = 16'd0;
      step();
      req = 16'h8001;
      step();
      chk("wrap_ptr0", 32'(gnt_idx), 32'd0);
      req = 16'd0;
      step();

      // Enable gating
      g_tag = "enable";
      en  = 1'b0;
      req = 16'h0100;
      repeat (5) begin
         step();
         chk("en_block", 32'(gnt), 32'h0);
      end
      en = 1'b1;
      step();
      chk("en_grant", 32'(gnt), 32'h0100);
      en = 1'b0;
      run(4);
      chk("en_persist", 32'(gnt), 32'h0100);
      req = 16'd0;
      step();
      chk("en_release", 32'(gnt), 32'h0);
      en = 1'b1;

      // No pre-emption
      g_tag = "nopreempt";
      req = 16'h0008;
      step();
      chk("nopre_own3", 32'(gnt), 32'h0008);
      req = 16'h0FF8;
      run(3);
      chk("nopre_hold", 32'(gnt), 32'h0008);
      req = 16'h0FF0;
      step();
      chk("nopre_idle", 32'(gnt), 32'h0);
      step();
      chk("nopre_next", 32'(gnt), 32'h0010);
      req = 16'd0;
      step();

      // Hold limit
      sync_reset();
      g_tag = "timeout";
      req = 16'h0041;
      step();
      chk("to_first", 32'(gnt), 32'h0001);
      run(7);
      chk("to_held8", 32'(gnt), 32'h0001);
      step();
`ifdef ARB_HOLD_TIMEOUT_EN
      chk("to_pulse", 32'(timeout), 32'd1);
      chk("to_idle", 32'(gnt), 32'h0);
      step();
      chk("to_pulse_end", 32'(timeout), 32'd0);
      chk("to_next", 32'(gnt), 32'h0040);
`else
      chk("to_unbounded", 32'(gnt), 32'h0001);
      run(10);
      chk("to_still_held", 32'(gnt), 32'h0001);
      chk("to_tied0", 32'(timeout), 32'd0);
`endif
      req = 16'd0;
      step();

      // Random traffic against the model
      g_tag = "random";
      repeat (600) begin
         req = 16'($urandom & $urandom);
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) req[m_owner] = 1'b1;
         en    = ($urandom_range(0, 4) != 0);
         rst_n = ($urandom_range(0, 99) != 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_dec_arbiter.md
Name: rr_dec_arbiter

Overview:
- 16-requester round-robin arbiter sharing a single resource among requesters.
- Outputs a 4-bit grant index plus a one-hot 16-bit grant vector, matching the 4-to-16 decoder output format (low half = index 0-7, high half = 8-15).
- Sits ahead of the decoder-driven select fabric: requesters raise `req`, the arbiter sequences ownership, and the owner holds it until it drops its request.

Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles per owner when the timeout feature is compiled in (legal range 2..255).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable; low blocks new grants only.
- req  input  16  request per requester, level-sensitive.
- gnt  output  16  one-hot grant, registered; all zero when no owner.
- gnt_idx  output  4  binary index of the owner; 0 when no owner.
- gnt_vld  output  1  high while a grant is active; equals OR of `gnt`.
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is out.

Behaviour:
- Reset (async assert, sync deassert is external):
  - gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Pointer ptr=0, hold counter=0, state=IDLE.
- Two states: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0, select the first set req bit scanning upward from ptr, wrapping 15->0.
  - Next edge: state=GRANT, gnt_idx=winner, gnt=1<<winner, gnt_vld=1, counter=0.
  - Otherwise remain in IDLE with outputs zero.
  - Latency from req sampled to gnt visible: 1 cycle.
- GRANT:
  - Grant holds unchanged while req[gnt_idx]=1.
  - Other req bits are ignored; no pre-emption.
  - en=0 does not revoke an existing grant.
- Release: when req[gnt_idx]=0 is sampled, next edge does all of:
  - state=IDLE
  - gnt=0, gnt_idx=0, gnt_vld=0
  - ptr=(owner+1) mod 16
- Minimum one idle cycle between consecutive grants; no back-to-back handover.
- Fairness: with all 16 requesting and each holding k cycles, every requester is granted once per 16*(k+1) cycles, order ascending from ptr.
- ptr is modulo-16 arithmetic; owner 15 sets ptr=0.
- ptr is unchanged while in IDLE with no grant.
- gnt is always one-hot or zero, never multi-hot. gnt and gnt_idx change on the same edge.
- A req bit asserted and dropped within a single IDLE cycle in which it is not selected is not remembered (no request latching).
- Reset mid-GRANT immediately clears all outputs asynchronously; arbitration restarts from ptr=0.

Optional Feature:
- Macro ARB_HOLD_TIMEOUT_EN.
- Defined:
  - Counter increments each GRANT cycle.
  - When the owner has held the grant HOLD_MAX cycles and req[gnt_idx] is still 1, the next edge forces release (same state updates as a normal release) and timeout=1 for exactly that one cycle.
  - If req drops on the same cycle the limit is reached, it is a normal release with timeout=0.
  - A timed-out requester still asserting req is eligible again only after the pointer rotates past it or no other requester is active.
- Undefined:
  - No counter logic; grant is unbounded; timeout tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-GRANT with owner 5 -> gnt=0, gnt_idx=0, gnt_vld=0 immediately; after release, req=0x0020 -> gnt=0x0020, gnt_idx=5 one cycle later.
- Rotation: req=0xFFFF held, each owner drops req for one cycle after 2 grant cycles then re-raises -> grant order 0,1,2,...,15,0, one idle cycle between grants.
- Wrap/pointer: ptr=14 (owner 13 just released), req=0x0003 -> winner 0; then req=0x8001 with ptr=1 -> winner 15, after release ptr=0.
- Enable: en=0, req=0x0100 for 5 cycles -> gnt stays 0; en=1 -> gnt=0x0100 next cycle. Drop en during that grant -> grant persists until req[8]=0.
- No pre-emption: owner 3 active, req changes from 0x0008 to 0x0FF8 -> gnt stays 0x0008; req[3] drops -> idle cycle, then gnt=0x0010.
- Timeout (macro defined, HOLD_MAX=8): req=0x0041 held -> gnt=0x0001 for 8 cycles, timeout pulse, idle cycle, gnt=0x0040; with macro undefined, gnt=0x0001 held indefinitely and timeout=0.
